// File: rtl/seq_divider.sv
// 32-bit signed sequential divider: one restoring step per cycle, 32 ITER cycles
// followed by a sign-fixup cycle, result held in DONE until the next start.
module seq_divider (
    input  logic        clk,
    input  logic        in_reset,
    input  logic        in_div_reset,
    input  logic [31:0] in_dividend,
    input  logic [31:0] in_divisor,
    output logic [31:0] out_quotient,
    output logic [31:0] out_remainder,
    output logic        out_busy,
    output logic        out_done,
    output logic        out_div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;

    logic [31:0] rem_reg;
    logic [31:0] quo_reg;
    logic [31:0] divisor_reg;
    logic [5:0]  cnt_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [31:0] quotient_reg;
    logic [31:0] remainder_reg;
    logic        dbz_reg;

    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [32:0] shifted_rem;
    logic [32:0] trial_diff;

    assign dividend_abs = in_dividend[31] ? (32'd0 - in_dividend) : in_dividend;
    assign divisor_abs  = in_divisor[31]  ? (32'd0 - in_divisor)  : in_divisor;

    // The partial remainder is always below the divisor magnitude, so only the
    // shifted trial value needs the 33rd bit.
    assign shifted_rem = {rem_reg, quo_reg[31]};
    assign trial_diff  = shifted_rem - {1'b0, divisor_reg};

    always_ff @(posedge clk or negedge in_reset) begin
        if (!in_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: state_next = IDLE;
            ITER: if (cnt_reg == 6'd31) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (in_div_reset) begin
            state_next = ITER;
        end
    end

    always_ff @(posedge clk or negedge in_reset) begin
        if (!in_reset) begin
            rem_reg       <= 32'd0;
            quo_reg       <= 32'd0;
            divisor_reg   <= 32'd0;
            cnt_reg       <= 6'd0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            quotient_reg  <= 32'd0;
            remainder_reg <= 32'd0;
            dbz_reg       <= 1'b0;
        end else if (in_div_reset) begin
            rem_reg     <= 32'd0;
            quo_reg     <= dividend_abs;
            divisor_reg <= divisor_abs;
            cnt_reg     <= 6'd0;
            neg_q_reg   <= in_dividend[31] ^ in_divisor[31];
            neg_r_reg   <= in_dividend[31];
            dbz_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ITER: begin
                    cnt_reg <= cnt_reg + 6'd1;
                    if (!trial_diff[32]) begin
                        rem_reg <= trial_diff[31:0];
                        quo_reg <= {quo_reg[30:0], 1'b1};
                    end else begin
                        rem_reg <= shifted_rem[31:0];
                        quo_reg <= {quo_reg[30:0], 1'b0};
                    end
                end
                FIX: begin
                    // A zero divisor leaves |dividend| in the remainder, so re-signing
                    // it restores the original dividend; the quotient is forced.
                    if (divisor_reg == 32'd0) begin
                        quotient_reg <= 32'hFFFF_FFFF;
                    end else begin
                        quotient_reg <= neg_q_reg ? (32'd0 - quo_reg) : quo_reg;
                    end
                    remainder_reg <= neg_r_reg ? (32'd0 - rem_reg) : rem_reg;
                    dbz_reg       <= (divisor_reg == 32'd0);
                end
                default: ;
            endcase
        end
    end

    assign out_quotient    = quotient_reg;
    assign out_remainder   = remainder_reg;
    assign out_busy        = (state_reg == ITER) || (state_reg == FIX);
    assign out_done        = (state_reg == DONE);
    assign out_div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider: an edge-counting arithmetic model is compared
// against the DUT on every falling edge, plus literal checks of known divisions.
module tb_seq_divider;

    logic        clk;
    logic        in_reset;
    logic        in_div_reset;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        out_busy;
    logic        out_done;
    logic        out_div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider dut (
        .clk             (clk),
        .in_reset        (in_reset),
        .in_div_reset    (in_div_reset),
        .in_dividend     (in_dividend),
        .in_divisor      (in_divisor),
        .out_quotient    (out_quotient),
        .out_remainder   (out_remainder),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_div_by_zero (out_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counts edges since the last start and produces the
    // arithmetic result 33 edges later.
    logic [31:0] m_a = 32'd0, m_b = 32'd0;
    logic [31:0] m_q = 32'd0, m_r = 32'd0;
    logic        m_dbz = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int          m_cnt = 0;

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endtask

    always @(posedge clk or negedge in_reset) begin
        if (!in_reset) begin
            m_q = 0; m_r = 0; m_dbz = 0; m_busy = 0; m_done = 0; m_cnt = 0;
            m_a = 0; m_b = 0;
        end else if (in_div_reset) begin
            m_a = in_dividend; m_b = in_divisor;
            m_cnt = 0; m_busy = 1; m_done = 0; m_dbz = 0;
        end else if (m_busy) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 33) begin
                ref_div(m_a, m_b, m_q, m_r);
                m_dbz  = (m_b == 32'd0);
                m_busy = 0;
                m_done = 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("busy",      {31'd0, out_busy},        {31'd0, m_busy});
        check("done",      {31'd0, out_done},        {31'd0, m_done});
        check("div0",      {31'd0, out_div_by_zero}, {31'd0, m_dbz});
        check("quotient",  out_quotient,  m_q);
        check("remainder", out_remainder, m_r);
    end

    // Called at posedge+1; the start edge is the next posedge.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        in_dividend  = a;
        in_divisor   = b;
        in_div_reset = 1'b1;
        @(posedge clk); #1;
        in_div_reset = 1'b0;
        in_dividend  = $urandom;
        in_divisor   = $urandom;
        $display("start %h / %h", a, b);
    endtask

    task automatic expect_result(input string name, input logic [31:0] q,
                                 input logic [31:0] r, input logic dbz);
        check({name, "_q"},    out_quotient,  q);
        check({name, "_r"},    out_remainder, r);
        check({name, "_dbz"},  {31'd0, out_div_by_zero}, {31'd0, dbz});
        check({name, "_done"}, {31'd0, out_done}, 32'd1);
        check({name, "_busy"}, {31'd0, out_busy}, 32'd0);
        $display("result %s q=%h r=%h dbz=%0d", name, out_quotient, out_remainder, out_div_by_zero);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd0 - 32'($urandom_range(1, 20));
            4: return 32'($urandom_range(0, 200));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        in_reset     = 1'b0;
        in_div_reset = 1'b0;
        in_dividend  = 32'd0;
        in_divisor   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q",    out_quotient, 32'd0);
        check("rst_busy", {31'd0, out_busy}, 32'd0);
        check("rst_done", {31'd0, out_done}, 32'd0);
        #2 in_reset = 1'b1;
        @(posedge clk); #1;

        start_div(32'd100, 32'd7);
        repeat (32) @(posedge clk);
        #1 check("lat_done_k32", {31'd0, out_done}, 32'd0);
        @(posedge clk); #1;
        expect_result("100/7", 32'd14, 32'd2, 1'b0);

        start_div(32'd0 - 32'd100, 32'd7);
        repeat (33) @(posedge clk); #1;
        expect_result("-100/7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

        start_div(32'd100, 32'd0 - 32'd7);
        repeat (33) @(posedge clk); #1;
        expect_result("100/-7", 32'hFFFF_FFF2, 32'd2, 1'b0);

        start_div(32'd7, 32'd0);
        repeat (33) @(posedge clk); #1;
        expect_result("7/0", 32'hFFFF_FFFF, 32'd7, 1'b1);

        start_div(32'd9, 32'd3);
        repeat (33) @(posedge clk); #1;
        expect_result("9/3", 32'd3, 32'd0, 1'b0);

        start_div(32'h8000_0000, 32'hFFFF_FFFF);
        repeat (33) @(posedge clk); #1;
        expect_result("min/-1", 32'h8000_0000, 32'd0, 1'b0);

        // Restart at edge k+10; the result lands at edge k+43.
        start_div(32'd50, 32'd5);
        repeat (9) @(posedge clk); #1;
        start_div(32'd81, 32'd9);
        repeat (32) @(posedge clk);
        #1 check("restart_done_early", {31'd0, out_done}, 32'd0);
        @(posedge clk); #1;
        expect_result("81/9", 32'd9, 32'd0, 1'b0);

        // Asynchronous reset mid-division.
        start_div(32'd1000, 32'd3);
        repeat (19) @(posedge clk);
        #3 in_reset = 1'b0;
        #1;
        check("arst_q",    out_quotient,  32'd0);
        check("arst_r",    out_remainder, 32'd0);
        check("arst_busy", {31'd0, out_busy}, 32'd0);
        check("arst_done", {31'd0, out_done}, 32'd0);
        $display("async reset applied mid-division");
        @(posedge clk);
        #3 in_reset = 1'b1;
        repeat (40) @(posedge clk); #1;
        check("post_rst_done", {31'd0, out_done}, 32'd0);
        check("post_rst_busy", {31'd0, out_busy}, 32'd0);

        // Start held high for several edges: only the last operands count.
        in_div_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_dividend = 32'd1000 + 32'(i);
            in_divisor  = 32'd10;
            @(posedge clk); #1;
        end
        in_div_reset = 1'b0;
        repeat (33) @(posedge clk); #1;
        expect_result("held_start", 32'd100, 32'd2, 1'b0);

        // Randomized divisions, some aborted by an early restart.
        for (int t = 0; t < 150; t++) begin
            int gap;
            start_div(pick_operand(), pick_operand());
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32))
                                               : 33 + int'($urandom_range(0, 3));
            repeat (gap) @(posedge clk);
            #1;
        end
        repeat (40) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
